axil_ram_v2: RTL and testbench
==============================

Name: axil_ram_v2

Overview:
- Parametrised AXI4-Lite slave RAM; successor to the single-beat always-ready RAM window.
- Adds:
  - independent AW/W acceptance
  - true backpressure on all channels
  - configurable base address and read latency
  - SLVERR on out-of-window accesses
  - asynchronous active-low reset
- Sits on the interconnect as a scratch/program memory slave.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; multiple of 8, in 32 or 64
- DEPTH_WORDS, 1024, number of DATA_W words; power of two
- BASE_ADDR, 0, byte address of word 0; aligned to DEPTH_WORDS*DATA_W/8
- RD_LAT, 1, cycles from AR handshake to RVALID; legal values 1 or 2

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- S_AWADDR  in  ADDR_W  write address
- S_AWVALID  in  1  write address valid
- S_AWREADY  out  1  write address ready
- S_WDATA  in  DATA_W  write data
- S_WSTRB  in  DATA_W/8  byte strobes
- S_WVALID  in  1  write data valid
- S_WREADY  out  1  write data ready
- S_BRESP  out  2  write response: 00 OKAY, 10 SLVERR
- S_BVALID  out  1  write response valid
- S_BREADY  in  1  write response ready
- S_ARADDR  in  ADDR_W  read address
- S_ARVALID  in  1  read address valid
- S_ARREADY  out  1  read address ready
- S_RDATA  out  DATA_W  read data
- S_RRESP  out  2  read response: 00 OKAY, 10 SLVERR
- S_RVALID  out  1  read data valid
- S_RREADY  in  1  read data ready

Behaviour:
- Reset (rst_n low, asynchronous):
  - write FSM to W_IDLE; read pipe empty
  - BVALID=0, RVALID=0, BRESP=00, RRESP=00, RDATA=0
  - AWREADY=WREADY=ARREADY=0 while rst_n low
  - memory contents not reset
  - reset mid-transaction drops the transaction silently; a write is committed only in the commit cycle.
- Address decode:
  - offset = ADDR - BASE_ADDR
  - in range iff ADDR >= BASE_ADDR and offset < DEPTH_WORDS*DATA_W/8
  - word index = offset >> log2(DATA_W/8); low byte-lane bits ignored, no unaligned error.
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - AWREADY = state in {W_IDLE, W_HAVE_W}, combinational from state.
  - WREADY = state in {W_IDLE, W_HAVE_AW}, combinational from state.
  - Handshake captures ADDR, or DATA+STRB, into holding registers.
  - W_IDLE, both handshakes same cycle: commit on that edge -> W_RESP; BVALID=1 next cycle.
  - W_IDLE, AW only -> W_HAVE_AW; W only -> W_HAVE_W.
  - W_HAVE_AW + W handshake, or W_HAVE_W + AW handshake: commit -> W_RESP.
  - Commit, in range: byte-lane merge under WSTRB (strobe 0 keeps the old byte). Out of range: no memory change, BRESP=10. WSTRB=0 in range: no change, BRESP=00.
  - W_RESP: BVALID held with BRESP stable until BREADY; on handshake -> W_IDLE. No new AW/W accepted in W_RESP.
- Read path: one outstanding read.
  - ARREADY=1 only when no read is in flight and RVALID=0.
  - AR handshake at edge N: RVALID=1 after edge N+RD_LAT-1, i.e. visible cycle N+RD_LAT.
  - RD_LAT=2 adds one register stage on the data.
  - Out of range: RDATA=0, RRESP=10.
  - RVALID/RDATA/RRESP held stable until RREADY; handshake clears RVALID. ARREADY reasserts the following cycle, giving 1 transaction per RD_LAT+1 cycles.
- Simultaneous read and write:
  - Channels are independent.
  - A read sampling the same word in the commit cycle returns the pre-write data; the following read returns the new data.
- Never asserts BVALID without a preceding commit, nor RVALID without a preceding AR handshake.

Test Plan:
1. Reset, then AW=BASE+0x10 and W=0xDEADBEEF, STRB=1111, same cycle -> BVALID next cycle, BRESP=00. AR=BASE+0x10 with RD_LAT=1 -> RVALID one cycle after AR handshake, RDATA=0xDEADBEEF, RRESP=00.
2. W (0x000000AA, STRB=0001) issued 3 cycles before AW=BASE+0x10 -> WREADY low after W handshake until commit. Read back 0xDEADBEAA.
3. Write to BASE+DEPTH_WORDS*4 -> BRESP=10, memory unchanged. Read the same address -> RDATA=0, RRESP=10.
4. Hold BREADY=0 and RREADY=0 for 5 cycles -> BVALID/RVALID and payloads stable; AWREADY/WREADY/ARREADY stay 0; a second AR is not accepted until the R handshake.
5. RD_LAT=2, write 0x12345678 to word 5, then issue AR in the commit cycle -> old value returned; the next AR returns 0x12345678, RVALID 2 cycles after each AR handshake.
6. Assert rst_n=0 while in W_HAVE_AW and with a read in flight -> BVALID=RVALID=0 immediately. After release, target word unchanged and a fresh write completes normally.

Source files
------------

// File: rtl/axil_ram_v2_if.sv
// AXI4-Lite slave bus bundle for axil_ram_v2.
// Signal names follow the S_* port names of the RAM.
interface axil_ram_v2_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AWADDR;
  logic                S_AWVALID;
  logic                S_AWREADY;
  logic [DATA_W-1:0]   S_WDATA;
  logic [DATA_W/8-1:0] S_WSTRB;
  logic                S_WVALID;
  logic                S_WREADY;
  logic [1:0]          S_BRESP;
  logic                S_BVALID;
  logic                S_BREADY;
  logic [ADDR_W-1:0]   S_ARADDR;
  logic                S_ARVALID;
  logic                S_ARREADY;
  logic [DATA_W-1:0]   S_RDATA;
  logic [1:0]          S_RRESP;
  logic                S_RVALID;
  logic                S_RREADY;

  modport slave (
    input  S_AWADDR, S_AWVALID,
    output S_AWREADY,
    input  S_WDATA, S_WSTRB, S_WVALID,
    output S_WREADY,
    output S_BRESP, S_BVALID,
    input  S_BREADY,
    input  S_ARADDR, S_ARVALID,
    output S_ARREADY,
    output S_RDATA, S_RRESP, S_RVALID,
    input  S_RREADY
  );

  modport master (
    output S_AWADDR, S_AWVALID,
    input  S_AWREADY,
    output S_WDATA, S_WSTRB, S_WVALID,
    input  S_WREADY,
    input  S_BRESP, S_BVALID,
    output S_BREADY,
    output S_ARADDR, S_ARVALID,
    input  S_ARREADY,
    input  S_RDATA, S_RRESP, S_RVALID,
    output S_RREADY
  );
endinterface

// File: rtl/axil_ram_v2.sv
// AXI4-Lite slave RAM with independent AW/W capture, full backpressure,
// base-address window with SLVERR, and 1- or 2-cycle read latency.
module axil_ram_v2 #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                RD_LAT      = 1
) (
  input logic           clk,
  input logic           rst_n,
  axil_ram_v2_if.slave  s_axil
);

  localparam int NB  = DATA_W / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] SPAN =
    (ADDR_W+1)'(DEPTH_WORDS * NB);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP
  } w_state_e;

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

  w_state_e          r_ws, w_ws_nxt;
  logic [ADDR_W-1:0] r_awaddr;
  logic [DATA_W-1:0] r_wdata;
  logic [NB-1:0]     r_wstrb;
  logic [1:0]        r_bresp;

  logic              w_aw_rdy, w_w_rdy;
  logic              w_aw_hs, w_w_hs, w_b_hs;
  logic              w_commit;
  logic [ADDR_W-1:0] w_c_addr, w_c_off;
  logic [DATA_W-1:0] w_c_data;
  logic [NB-1:0]     w_c_strb;
  logic              w_c_in;
  logic [IW-1:0]     w_c_idx;

  assign w_aw_rdy = rst_n &
    ((r_ws == W_IDLE) | (r_ws == W_HAVE_W));
  assign w_w_rdy  = rst_n &
    ((r_ws == W_IDLE) | (r_ws == W_HAVE_AW));
  assign w_aw_hs  = s_axil.S_AWVALID & w_aw_rdy;
  assign w_w_hs   = s_axil.S_WVALID & w_w_rdy;
  assign w_b_hs   = (r_ws == W_RESP) & s_axil.S_BREADY;

  // The half that arrived first is taken from its holding register.
  assign w_c_addr = (r_ws == W_HAVE_AW) ? r_awaddr
                                        : s_axil.S_AWADDR;
  assign w_c_data = (r_ws == W_HAVE_W) ? r_wdata
                                       : s_axil.S_WDATA;
  assign w_c_strb = (r_ws == W_HAVE_W) ? r_wstrb
                                       : s_axil.S_WSTRB;
  assign w_c_off  = w_c_addr - BASE_ADDR;
  assign w_c_in   = (w_c_addr >= BASE_ADDR) &
                    ({1'b0, w_c_off} < SPAN);
  assign w_c_idx  = w_c_off[LSB +: IW];

  always_comb begin
    w_ws_nxt = r_ws;
    w_commit = 1'b0;
    unique case (r_ws)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_commit = 1'b1;
          w_ws_nxt = W_RESP;
        end else if (w_aw_hs) begin
          w_ws_nxt = W_HAVE_AW;
        end else if (w_w_hs) begin
          w_ws_nxt = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_w_hs) begin
          w_commit = 1'b1;
          w_ws_nxt = W_RESP;
        end
      end
      W_HAVE_W: begin
        if (w_aw_hs) begin
          w_commit = 1'b1;
          w_ws_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (w_b_hs) w_ws_nxt = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ws     <= W_IDLE;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= OKAY;
    end else begin
      r_ws <= w_ws_nxt;
      if (w_aw_hs) r_awaddr <= s_axil.S_AWADDR;
      if (w_w_hs) begin
        r_wdata <= s_axil.S_WDATA;
        r_wstrb <= s_axil.S_WSTRB;
      end
      if (w_commit) r_bresp <= w_c_in ? OKAY : SLVERR;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (w_commit && w_c_in && w_c_strb[b])
        r_mem[w_c_idx][b*8 +: 8] <= w_c_data[b*8 +: 8];
    end
  end

  assign s_axil.S_AWREADY = w_aw_rdy;
  assign s_axil.S_WREADY  = w_w_rdy;
  assign s_axil.S_BVALID  = (r_ws == W_RESP);
  assign s_axil.S_BRESP   = r_bresp;

  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;
  logic              w_busy, w_ar_rdy, w_ar_hs, w_r_hs;
  logic [ADDR_W-1:0] w_ar_off;
  logic              w_ar_in;
  logic [IW-1:0]     w_ar_idx;
  logic [DATA_W-1:0] w_rd_data;
  logic [1:0]        w_rd_resp;
  logic              w_ld;
  logic [DATA_W-1:0] w_ld_data;
  logic [1:0]        w_ld_resp;

  assign w_ar_rdy  = rst_n & ~w_busy & ~r_rvalid;
  assign w_ar_hs   = s_axil.S_ARVALID & w_ar_rdy;
  assign w_r_hs    = r_rvalid & s_axil.S_RREADY;
  assign w_ar_off  = s_axil.S_ARADDR - BASE_ADDR;
  assign w_ar_in   = (s_axil.S_ARADDR >= BASE_ADDR) &
                     ({1'b0, w_ar_off} < SPAN);
  assign w_ar_idx  = w_ar_off[LSB +: IW];
  assign w_rd_data = w_ar_in ? r_mem[w_ar_idx] : '0;
  assign w_rd_resp = w_ar_in ? OKAY : SLVERR;

  if (RD_LAT == 2) begin : g_lat2
    logic              r_p_vld;
    logic [DATA_W-1:0] r_p_data;
    logic [1:0]        r_p_resp;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_p_vld  <= 1'b0;
        r_p_data <= '0;
        r_p_resp <= OKAY;
      end else begin
        r_p_vld <= w_ar_hs;
        if (w_ar_hs) begin
          r_p_data <= w_rd_data;
          r_p_resp <= w_rd_resp;
        end
      end
    end

    assign w_busy    = r_p_vld;
    assign w_ld      = r_p_vld;
    assign w_ld_data = r_p_data;
    assign w_ld_resp = r_p_resp;
  end else begin : g_lat1
    assign w_busy    = 1'b0;
    assign w_ld      = w_ar_hs;
    assign w_ld_data = w_rd_data;
    assign w_ld_resp = w_rd_resp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= OKAY;
    end else if (w_ld) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_ld_data;
      r_rresp  <= w_ld_resp;
    end else if (w_r_hs) begin
      r_rvalid <= 1'b0;
    end
  end

  assign s_axil.S_ARREADY = w_ar_rdy;
  assign s_axil.S_RVALID  = r_rvalid;
  assign s_axil.S_RDATA   = r_rdata;
  assign s_axil.S_RRESP   = r_rresp;

endmodule

// File: tb/tb_axil_ram_v2.sv
// Scoreboard bench for axil_ram_v2: one RD_LAT=1 and one RD_LAT=2
// instance share the write channel; reads go to either instance.
module tb_axil_ram_v2;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] SPAN = 32'h0000_1000;
  localparam int          TMO  = 200;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
  } rexp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        bready = 1'b0;
  logic        rready = 1'b0;
  logic [31:0] araddr1 = '0, araddr2 = '0;
  logic        arvalid1 = 1'b0, arvalid2 = 1'b0;
  bit          hold = 1'b0;
  bit          rnd_bp = 1'b0;

  axil_ram_v2_if #(.ADDR_W(32), .DATA_W(32)) if1 ();
  axil_ram_v2_if #(.ADDR_W(32), .DATA_W(32)) if2 ();

  assign if1.S_AWADDR  = awaddr;
  assign if1.S_AWVALID = awvalid;
  assign if1.S_WDATA   = wdata;
  assign if1.S_WSTRB   = wstrb;
  assign if1.S_WVALID  = wvalid;
  assign if1.S_BREADY  = bready;
  assign if1.S_ARADDR  = araddr1;
  assign if1.S_ARVALID = arvalid1;
  assign if1.S_RREADY  = rready;
  assign if2.S_AWADDR  = awaddr;
  assign if2.S_AWVALID = awvalid;
  assign if2.S_WDATA   = wdata;
  assign if2.S_WSTRB   = wstrb;
  assign if2.S_WVALID  = wvalid;
  assign if2.S_BREADY  = bready;
  assign if2.S_ARADDR  = araddr2;
  assign if2.S_ARVALID = arvalid2;
  assign if2.S_RREADY  = rready;

  axil_ram_v2 #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024),
    .BASE_ADDR(BASE), .RD_LAT(1)
  ) u_lat1 (
    .clk(clk), .rst_n(rst_n), .s_axil(if1.slave)
  );

  axil_ram_v2 #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024),
    .BASE_ADDR(BASE), .RD_LAT(2)
  ) u_lat2 (
    .clk(clk), .rst_n(rst_n), .s_axil(if2.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endfunction

  function automatic void fail(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout/unexpected (t=%0t)", nm, $time);
  endfunction

  // Reference model: flat word array addressed by byte offset / 4.
  logic [31:0] mdl [1024];
  rexp_t       q_r1[$], q_r2[$];
  logic [1:0]  q_b1[$], q_b2[$];

  function automatic bit in_win(logic [31:0] a);
    return (a >= BASE) && (a < BASE + SPAN);
  endfunction

  function automatic rexp_t model_read(logic [31:0] a);
    rexp_t e;
    if (in_win(a)) begin
      e.d = mdl[int'((a - BASE) >> 2)];
      e.r = 2'b00;
    end else begin
      e.d = '0;
      e.r = 2'b10;
    end
    return e;
  endfunction

  function automatic void expect_write(logic [31:0] a,
                                       logic [31:0] d,
                                       logic [3:0] s);
    logic [1:0] r;
    int         idx;
    r = 2'b10;
    if (in_win(a)) begin
      r = 2'b00;
      idx = int'((a - BASE) >> 2);
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
    end
    q_b1.push_back(r);
    q_b2.push_back(r);
  endfunction

  // Ready driver: held low, random backpressure, or always ready.
  always @(posedge clk) begin
    #1;
    if (hold) begin
      bready = 1'b0;
      rready = 1'b0;
    end else if (rnd_bp) begin
      bready = ($urandom_range(0, 3) != 0);
      rready = ($urandom_range(0, 3) != 0);
    end else begin
      bready = 1'b1;
      rready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every B/R handshake.
  always @(negedge clk) begin
    logic [1:0] eb;
    rexp_t      er;
    if (rst_n) begin
      if (if1.S_BVALID && if1.S_BREADY) begin
        if (q_b1.size() == 0) fail("b1_unexpected");
        else begin
          eb = q_b1.pop_front();
          chk("b1_resp", 64'(if1.S_BRESP), 64'(eb));
        end
      end
      if (if2.S_BVALID && if2.S_BREADY) begin
        if (q_b2.size() == 0) fail("b2_unexpected");
        else begin
          eb = q_b2.pop_front();
          chk("b2_resp", 64'(if2.S_BRESP), 64'(eb));
        end
      end
      if (if1.S_RVALID && if1.S_RREADY) begin
        if (q_r1.size() == 0) fail("r1_unexpected");
        else begin
          er = q_r1.pop_front();
          chk("r1_data", 64'(if1.S_RDATA), 64'(er.d));
          chk("r1_resp", 64'(if1.S_RRESP), 64'(er.r));
        end
      end
      if (if2.S_RVALID && if2.S_RREADY) begin
        if (q_r2.size() == 0) fail("r2_unexpected");
        else begin
          er = q_r2.pop_front();
          chk("r2_data", 64'(if2.S_RDATA), 64'(er.d));
          chk("r2_resp", 64'(if2.S_RRESP), 64'(er.r));
        end
      end
    end
  end

  task automatic drive_aw(input logic [31:0] a);
    bit ok;
    ok = 1'b0;
    awaddr = a;
    awvalid = 1'b1;
    for (int n = 0; n < TMO; n++) begin
      @(negedge clk);
      if (if1.S_AWREADY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("aw_handshake");
    else chk("aw2_ready", 64'(if2.S_AWREADY), 64'd1);
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    awaddr = $urandom;
  endtask

  task automatic drive_w(input logic [31:0] d,
                         input logic [3:0] s);
    bit ok;
    ok = 1'b0;
    wdata = d;
    wstrb = s;
    wvalid = 1'b1;
    for (int n = 0; n < TMO; n++) begin
      @(negedge clk);
      if (if1.S_WREADY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("w_handshake");
    else chk("w2_ready", 64'(if2.S_WREADY), 64'd1);
    @(posedge clk);
    #1;
    wvalid = 1'b0;
    wdata = $urandom;
    wstrb = 4'($urandom);
  endtask

  task automatic do_write(input logic [31:0] a,
                          input logic [31:0] d,
                          input logic [3:0] s,
                          input int awd, input int wd);
    expect_write(a, d, s);
    fork
      begin
        repeat (awd) begin @(posedge clk); #1; end
        drive_aw(a);
      end
      begin
        repeat (wd) begin @(posedge clk); #1; end
        drive_w(d, s);
      end
    join
  endtask

  task automatic do_read(input int which,
                         input logic [31:0] a);
    rexp_t e;
    bit    ok;
    int    lat;
    e = model_read(a);
    ok = 1'b0;
    if (which == 1) begin araddr1 = a; arvalid1 = 1'b1; end
    else begin araddr2 = a; arvalid2 = 1'b1; end
    for (int n = 0; n < TMO; n++) begin
      @(negedge clk);
      if ((which == 1) ? if1.S_ARREADY : if2.S_ARREADY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("ar_handshake");
    else if (which == 1) q_r1.push_back(e);
    else q_r2.push_back(e);
    @(posedge clk);
    #1;
    arvalid1 = 1'b0;
    arvalid2 = 1'b0;
    araddr1 = $urandom;
    araddr2 = $urandom;
    if (ok) begin
      lat = 0;
      for (int n = 1; n <= 8; n++) begin
        @(negedge clk);
        if ((which == 1) ? if1.S_RVALID : if2.S_RVALID) begin
          lat = n;
          break;
        end
      end
      chk((which == 1) ? "rd_lat1" : "rd_lat2",
          64'(lat), 64'(which));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q_b1.size() + q_b2.size() + q_r1.size() +
            q_r2.size() != 0 || if1.S_BVALID || if1.S_RVALID ||
            if2.S_RVALID) && n < TMO) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= TMO) fail("wait_idle");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rexp_t      e_old;
    logic [31:0] a, d;
    int         op;
    logic [31:0] oor [4];
    oor[0] = 32'h0;
    oor[1] = BASE - 32'd4;
    oor[2] = BASE + SPAN;
    oor[3] = 32'hFFFF_FFFC;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 64'(if1.S_AWREADY), 64'd0);
    chk("rst_wready", 64'(if1.S_WREADY), 64'd0);
    chk("rst_arready1", 64'(if1.S_ARREADY), 64'd0);
    chk("rst_arready2", 64'(if2.S_ARREADY), 64'd0);
    chk("rst_bvalid", 64'(if1.S_BVALID), 64'd0);
    chk("rst_rvalid1", 64'(if1.S_RVALID), 64'd0);
    chk("rst_rvalid2", 64'(if2.S_RVALID), 64'd0);
    chk("rst_bresp", 64'(if1.S_BRESP), 64'd0);
    chk("rst_rresp", 64'(if1.S_RRESP), 64'd0);
    chk("rst_rdata1", 64'(if1.S_RDATA), 64'd0);
    chk("rst_rdata2", 64'(if2.S_RDATA), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_awready", 64'(if1.S_AWREADY), 64'd1);
    chk("idle_wready", 64'(if1.S_WREADY), 64'd1);
    chk("idle_arready1", 64'(if1.S_ARREADY), 64'd1);
    chk("idle_arready2", 64'(if2.S_ARREADY), 64'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++)
      do_write(BASE + 32'(i * 4), $urandom, 4'hF, 0, 0);
    wait_idle();

    // Same-cycle AW/W; BVALID the cycle after commit.
    do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
    chk("t1_bvalid", 64'(if1.S_BVALID), 64'd1);
    do_read(1, BASE + 32'h10);
    do_read(2, BASE + 32'h10);
    wait_idle();

    // W three cycles ahead of AW, single byte lane.
    expect_write(BASE + 32'h10, 32'h0000_00AA, 4'h1);
    drive_w(32'h0000_00AA, 4'h1);
    repeat (3) begin
      @(negedge clk);
      chk("t2_wready_low", 64'(if1.S_WREADY), 64'd0);
      chk("t2_awready", 64'(if1.S_AWREADY), 64'd1);
      @(posedge clk);
      #1;
    end
    drive_aw(BASE + 32'h10);
    chk("t2_model", 64'(mdl[4]), 64'hDEAD_BEAA);
    do_read(1, BASE + 32'h10);
    wait_idle();

    // Window edges, out-of-range, zero strobe.
    do_write(BASE + SPAN, 32'h5555_5555, 4'hF, 0, 0);
    do_read(1, BASE + SPAN);
    do_read(1, BASE);
    do_read(2, BASE - 32'd4);
    do_write(BASE + 32'hFFC, 32'hCAFE_F00D, 4'hF, 1, 0);
    do_read(1, BASE + 32'hFFE);
    do_read(2, BASE + 32'hFFC);
    do_write(BASE + 32'h8, 32'hFFFF_FFFF, 4'h0, 0, 2);
    do_read(1, BASE + 32'h8);
    wait_idle();

    // Backpressure on B and R for five cycles.
    hold = 1'b1;
    bready = 1'b0;
    rready = 1'b0;
    fork
      do_write(BASE + 32'h20, 32'h0BAD_CAFE, 4'hF, 0, 0);
      do_read(1, BASE + 32'h24);
    join
    repeat (5) begin
      @(negedge clk);
      chk("t4_bvalid", 64'(if1.S_BVALID), 64'd1);
      chk("t4_bresp", 64'(if1.S_BRESP), 64'd0);
      chk("t4_rvalid", 64'(if1.S_RVALID), 64'd1);
      chk("t4_rdata", 64'(if1.S_RDATA), 64'(mdl[9]));
      chk("t4_awready", 64'(if1.S_AWREADY), 64'd0);
      chk("t4_wready", 64'(if1.S_WREADY), 64'd0);
      chk("t4_arready", 64'(if1.S_ARREADY), 64'd0);
    end
    @(posedge clk);
    #1;
    hold = 1'b0;
    wait_idle();

    // RD_LAT=2 read sampled in the commit cycle sees old data.
    e_old = model_read(BASE + 32'h14);
    awaddr = BASE + 32'h14;
    awvalid = 1'b1;
    wdata = 32'h1234_5678;
    wstrb = 4'hF;
    wvalid = 1'b1;
    araddr2 = BASE + 32'h14;
    arvalid2 = 1'b1;
    @(negedge clk);
    chk("t5_awready", 64'(if1.S_AWREADY), 64'd1);
    chk("t5_wready", 64'(if1.S_WREADY), 64'd1);
    chk("t5_arready", 64'(if2.S_ARREADY), 64'd1);
    q_r2.push_back(e_old);
    expect_write(BASE + 32'h14, 32'h1234_5678, 4'hF);
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    wvalid = 1'b0;
    arvalid2 = 1'b0;
    @(negedge clk);
    chk("t5_rvalid_c1", 64'(if2.S_RVALID), 64'd0);
    @(negedge clk);
    chk("t5_rvalid_c2", 64'(if2.S_RVALID), 64'd1);
    @(posedge clk);
    #1;
    do_read(2, BASE + 32'h14);
    wait_idle();

    // Reset with write half-captured and reads in flight.
    awaddr = BASE + 32'h1C;
    awvalid = 1'b1;
    araddr1 = BASE + 32'h1C;
    arvalid1 = 1'b1;
    araddr2 = BASE + 32'h1C;
    arvalid2 = 1'b1;
    @(negedge clk);
    chk("t6_awready", 64'(if1.S_AWREADY), 64'd1);
    chk("t6_arready1", 64'(if1.S_ARREADY), 64'd1);
    chk("t6_arready2", 64'(if2.S_ARREADY), 64'd1);
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    arvalid1 = 1'b0;
    arvalid2 = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_bvalid", 64'(if1.S_BVALID), 64'd0);
    chk("t6_rvalid1", 64'(if1.S_RVALID), 64'd0);
    chk("t6_rvalid2", 64'(if2.S_RVALID), 64'd0);
    chk("t6_rdata1", 64'(if1.S_RDATA), 64'd0);
    chk("t6_awready_rst", 64'(if1.S_AWREADY), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_wready_rel", 64'(if1.S_WREADY), 64'd1);
    @(posedge clk);
    #1;
    do_read(1, BASE + 32'h1C);
    do_read(2, BASE + 32'h1C);
    do_write(BASE + 32'h1C, 32'h7777_1111, 4'hF, 0, 1);
    do_read(1, BASE + 32'h1C);
    wait_idle();

    // Random traffic with random backpressure.
    rnd_bp = 1'b1;
    for (int it = 0; it < 120; it++) begin
      op = int'($urandom_range(0, 5));
      if ($urandom_range(0, 5) == 0)
        a = oor[$urandom_range(0, 3)];
      else
        a = BASE + 32'($urandom_range(0, 15) * 4) +
            32'($urandom_range(0, 3));
      d = $urandom;
      if (op < 3)
        do_write(a, d, 4'($urandom), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)));
      else
        do_read((op == 5) ? 2 : 1, a);
    end
    wait_idle();
    rnd_bp = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
